fma_operand_loader: RTL and testbench

Serial-to-parallel operand front end for the `fma` datapath. Collects two MSB-first serial bit streams (one per operand) into WIDTH-bit words under frame control. Presents each completed operand pair to the `fma` stage through a valid/ready handshake. A one-word skid register lets the next frame shift in while the `fma` stage holds the current pair.

---
 rtl/fma_operand_loader.sv | 158 +++++++++++++++
 tb/tb_fma_operand_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fma_operand_loader.sv
// Serial-to-parallel operand front end for the fma datapath: two MSB-first bit
// streams are framed into WIDTH-bit words and handed over with valid/ready.
module fma_operand_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             frame_start,
    input  logic             ser_a,
    input  logic             ser_b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] ina,
    output logic [WIDTH-1:0] inb,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             busy,
    output logic             frame_err,
    output logic [1:0]       dbg_state
);

    // Handshake: ina/inb are offered while op_valid is high; a pair is consumed
    // on every cycle where op_valid && op_ready, and ina/inb stay stable until then.

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sa_n;
    logic [WIDTH-1:0] sb_n;
    logic [WIDTH-1:0] sa_shift;
    logic [WIDTH-1:0] sb_shift;
    logic [WIDTH-1:0] ina_n;
    logic [WIDTH-1:0] inb_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic             op_valid_n;
    logic             err_set;
    logic             frame_err_n;
    logic             slot_free;
    logic             last_bit;

    assign sa_shift  = {sa[WIDTH-2:0], ser_a};
    assign sb_shift  = {sb[WIDTH-2:0], ser_b};
    assign slot_free = !op_valid || op_ready;
    assign last_bit  = (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            cnt       <= '0;
            ina       <= '0;
            inb       <= '0;
            op_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            sa        <= sa_n;
            sb        <= sb_n;
            cnt       <= cnt_n;
            ina       <= ina_n;
            inb       <= inb_n;
            op_valid  <= op_valid_n;
            frame_err <= frame_err_n;
        end
    end

    always_comb begin
        state_n    = state;
        sa_n       = sa;
        sb_n       = sb;
        cnt_n      = cnt;
        ina_n      = ina;
        inb_n      = inb;
        op_valid_n = op_valid && !op_ready;
        err_set    = 1'b0;

        case (state)
            IDLE: begin
                if (enable && frame_start) begin
                    sa_n    = sa_shift;
                    sb_n    = sb_shift;
                    cnt_n   = ONE_CNT;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (enable) begin
                    if (frame_start && (cnt < FULL_CNT)) begin
                        // Restart: the current bit is the MSB of a fresh frame.
                        sa_n    = sa_shift;
                        sb_n    = sb_shift;
                        cnt_n   = ONE_CNT;
                        err_set = 1'b1;
                    end else if (last_bit) begin
                        if (slot_free) begin
                            ina_n      = sa_shift;
                            inb_n      = sb_shift;
                            op_valid_n = 1'b1;
                            cnt_n      = '0;
                            state_n    = IDLE;
                        end else begin
                            sa_n    = sa_shift;
                            sb_n    = sb_shift;
                            cnt_n   = cnt + ONE_CNT;
                            state_n = HOLD;
                        end
                    end else begin
                        sa_n  = sa_shift;
                        sb_n  = sb_shift;
                        cnt_n = cnt + ONE_CNT;
                    end
                end
            end
            HOLD: begin
                // A held pair plus a full output register: any new frame is an overrun.
                if (enable && frame_start) begin
                    err_set = 1'b1;
                end
                if (op_ready) begin
                    ina_n      = sa;
                    inb_n      = sb;
                    op_valid_n = 1'b1;
                    cnt_n      = '0;
                    state_n    = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (err_set) begin
            frame_err_n = 1'b1;
        end else if (clr_err) begin
            frame_err_n = 1'b0;
        end else begin
            frame_err_n = frame_err;
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_fma_operand_loader.sv
// Directed bench for fma_operand_loader: per-cycle checks against hand-derived
// timing plus a transfer scoreboard of expected operand pairs.
module tb_fma_operand_loader;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         frame_start;
    logic         ser_a;
    logic         ser_b;
    logic         clr_err;
    logic [W-1:0] ina;
    logic [W-1:0] inb;
    logic         op_valid;
    logic         op_ready;
    logic         busy;
    logic         frame_err;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q[$];

    fma_operand_loader #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .frame_start (frame_start),
        .ser_a       (ser_a),
        .ser_b       (ser_b),
        .clr_err     (clr_err),
        .ina         (ina),
        .inb         (inb),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .busy        (busy),
        .frame_err   (frame_err),
        .dbg_state   (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fs, input logic a, input logic b);
        frame_start = fs;
        ser_a       = a;
        ser_b       = b;
        tick();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        enable      = 1'b1;
        frame_start = 1'b0;
        ser_a       = 1'b0;
        ser_b       = 1'b0;
        clr_err     = 1'b0;
        op_ready    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // scoreboard: every accepted pair must match the oldest expected pair
    always @(negedge clk) begin
        if (!reset && op_valid && op_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", 32'({ina, inb}), 32'hffff_ffff);
            end else begin
                check("sb_pair", 32'({ina, inb}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [W-1:0] wa;
        logic [W-1:0] wb;
        logic [W-1:0] wa2;
        logic [W-1:0] wb2;
        int           idx;

        do_reset();
        check("rst_ina", 32'(ina), 32'h0);
        check("rst_inb", 32'(inb), 32'h0);
        check("rst_valid", 32'(op_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(frame_err), 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);

        // basic load
        op_ready = 1'b1;
        wa = 8'hA5;
        wb = 8'h3C;
        exp_q.push_back({wa, wb});
        for (int c = 0; c < 10; c++) begin
            check("t1_valid", 32'(op_valid), 32'(c == 8));
            check("t1_busy", 32'(busy), 32'(c >= 1 && c <= 7));
            if (c == 8) begin
                check("t1_ina", 32'(ina), 32'hA5);
                check("t1_inb", 32'(inb), 32'h3C);
            end
            check("t1_err", 32'(frame_err), 32'h0);
            if (c < 8) drive(c == 0, wa[7-c], wb[7-c]);
            else drive(1'b0, 1'b0, 1'b0);
        end

        // back-to-back frames
        wa = 8'h01; wb = 8'hFF; wa2 = 8'h80; wb2 = 8'h7E;
        exp_q.push_back({wa, wb});
        exp_q.push_back({wa2, wb2});
        for (int c = 0; c < 18; c++) begin
            check("t2_valid", 32'(op_valid), 32'(c == 8 || c == 16));
            if (c == 8) check("t2_pair0", 32'({ina, inb}), 32'h01FF);
            if (c == 16) check("t2_pair1", 32'({ina, inb}), 32'h807E);
            idx = 7 - (c % 8);
            if (c < 8) drive(c == 0, wa[idx], wb[idx]);
            else if (c < 16) drive(c == 8, wa2[idx], wb2[idx]);
            else drive(1'b0, 1'b0, 1'b0);
        end

        // backpressure: two frames stack up, third start is an overrun
        wa = 8'h11; wb = 8'h22; wa2 = 8'h33; wb2 = 8'h44;
        exp_q.push_back({wa, wb});
        exp_q.push_back({wa2, wb2});
        for (int c = 0; c < 24; c++) begin
            op_ready = (c >= 20);
            clr_err  = (c == 22);
            if (c >= 8 && c <= 20) begin
                check("t3_hold_valid", 32'(op_valid), 32'h1);
                check("t3_hold_pair", 32'({ina, inb}), 32'h1122);
            end
            if (c >= 16 && c <= 20) begin
                check("t3_busy", 32'(busy), 32'h1);
                check("t3_state", 32'(dbg_state), 32'h2);
            end
            if (c == 16) check("t3_err_pre", 32'(frame_err), 32'h0);
            if (c == 17) check("t3_err_set", 32'(frame_err), 32'h1);
            if (c == 21) begin
                check("t3_valid21", 32'(op_valid), 32'h1);
                check("t3_pair21", 32'({ina, inb}), 32'h3344);
                check("t3_busy21", 32'(busy), 32'h0);
            end
            if (c == 22) check("t3_valid22", 32'(op_valid), 32'h0);
            if (c == 23) check("t3_err_clr", 32'(frame_err), 32'h0);
            idx = 7 - (c % 8);
            if (c < 8) drive(c == 0, wa[idx], wb[idx]);
            else if (c < 16) drive(c == 8, wa2[idx], wb2[idx]);
            else drive(c == 16, 1'b1, 1'b0);
        end
        clr_err  = 1'b0;
        op_ready = 1'b1;

        // enable gap of 3 cycles after four bits
        wa = 8'hC3; wb = 8'h5A;
        exp_q.push_back({wa, wb});
        for (int c = 0; c < 13; c++) begin
            check("t4_valid", 32'(op_valid), 32'(c == 11));
            if (c >= 4 && c <= 6) check("t4_busy_gap", 32'(busy), 32'h1);
            if (c == 11) check("t4_pair", 32'({ina, inb}), 32'hC35A);
            if (c == 12) check("t4_err", 32'(frame_err), 32'h0);
            enable = !(c >= 4 && c <= 6);
            if (c < 4) drive(c == 0, wa[7-c], wb[7-c]);
            else if (c <= 6) drive(1'b1, ~wa[3], ~wb[3]);
            else if (c <= 10) drive(1'b0, wa[7-(c-3)], wb[7-(c-3)]);
            else drive(1'b0, 1'b0, 1'b0);
        end
        enable = 1'b1;

        // restart at cnt=5 with a simultaneous clear (set wins), then clear
        wa = 8'h96; wb = 8'h69;
        exp_q.push_back({wa, wb});
        for (int c = 0; c < 15; c++) begin
            clr_err = (c == 5) || (c == 13);
            check("t5_valid", 32'(op_valid), 32'(c == 13));
            if (c == 0) check("t5_err0", 32'(frame_err), 32'h0);
            if (c == 6) check("t5_err_set", 32'(frame_err), 32'h1);
            if (c == 13) begin
                check("t5_err_held", 32'(frame_err), 32'h1);
                check("t5_pair", 32'({ina, inb}), 32'h9669);
            end
            if (c == 14) check("t5_err_clr", 32'(frame_err), 32'h0);
            if (c < 5) drive(c == 0, 1'b1, 1'b1);
            else if (c <= 12) drive(c == 5, wa[7-(c-5)], wb[7-(c-5)]);
            else drive(1'b0, 1'b0, 1'b0);
        end
        clr_err = 1'b0;

        // reset while one pair is held on the outputs and another is half shifted
        op_ready = 1'b0;
        wa = 8'hE7; wb = 8'h18; wa2 = 8'hAA; wb2 = 8'h55;
        for (int c = 0; c < 13; c++) begin
            if (c >= 8) check("t6_valid_pre", 32'(op_valid), 32'h1);
            reset = (c == 12);
            idx = 7 - (c % 8);
            if (c < 8) drive(c == 0, wa[idx], wb[idx]);
            else if (c < 12) drive(c == 8, wa2[idx], wb2[idx]);
            else drive(1'b0, 1'b1, 1'b1);
        end
        reset = 1'b0;
        check("t6_ina", 32'(ina), 32'h0);
        check("t6_inb", 32'(inb), 32'h0);
        check("t6_valid", 32'(op_valid), 32'h0);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_err", 32'(frame_err), 32'h0);
        op_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check("t6_idle_valid", 32'(op_valid), 32'h0);
            check("t6_idle_busy", 32'(busy), 32'h0);
        end
        wa = 8'h5C; wb = 8'hC5;
        exp_q.push_back({wa, wb});
        for (int c = 0; c < 10; c++) begin
            check("t6_fresh_valid", 32'(op_valid), 32'(c == 8));
            if (c == 8) check("t6_fresh_pair", 32'({ina, inb}), 32'h5CC5);
            if (c < 8) drive(c == 0, wa[7-c], wb[7-c]);
            else drive(1'b0, 1'b0, 1'b0);
        end

        // final report
        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
